// File: rtl/doodle_pkg.sv
// Shared types and default constants for the doodle vertical-motion controller.
package doodle_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASCEND  = 2'd1,
      ST_DESCEND = 2'd2,
      ST_DEAD    = 2'd3
   } state_e;

   localparam int SCREEN_H  = 480;
   localparam int DOODLE_H  = 20;
   localparam int Y_W       = 10;
   localparam int V_W       = 8;
   localparam int Y_START   = 400;
   localparam int FLOOR_Y   = SCREEN_H - DOODLE_H;
   localparam int JUMP_V    = 8;
   localparam int BOOST_V   = 16;
   localparam int GRAVITY   = 1;
   localparam int VMAX_FALL = 8;

endpackage

// File: rtl/doodle_vmotion_tick_sync.sv
// Two-flop synchronizer for a slow divider square wave with a rising-edge tick.
module tick_sync (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic tick
);
   import doodle_pkg::*;

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= async_in;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign tick = sync2_q & ~prev_q;

endmodule

// File: rtl/doodle_vmotion.sv
// Doodle vertical motion: integrates velocity/position on divider ticks,
// bounces on platforms, and detects falling off the bottom of the screen.
module doodle_vmotion #(
   parameter int Y_W       = doodle_pkg::Y_W,
   parameter int V_W       = doodle_pkg::V_W,
   parameter int Y_START   = doodle_pkg::Y_START,
   parameter int FLOOR_Y   = doodle_pkg::FLOOR_Y,
   parameter int JUMP_V    = doodle_pkg::JUMP_V,
   parameter int BOOST_V   = doodle_pkg::BOOST_V,
   parameter int GRAVITY   = doodle_pkg::GRAVITY,
   parameter int VMAX_FALL = doodle_pkg::VMAX_FALL
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  doodle_clk,
   input  logic                  gravity_clk,
   input  logic                  start,
   input  logic                  landed,
   input  logic                  power_signal,
   output logic [Y_W-1:0]        doodle_y,
   output logic signed [V_W-1:0] velocity,
   output logic                  jump_pulse,
   output logic                  falling,
   output logic                  dead
);
   import doodle_pkg::*;

   localparam logic [Y_W-1:0]        Y_START_C = Y_W'(Y_START);
   localparam logic [Y_W-1:0]        FLOOR_C   = Y_W'(FLOOR_Y);
   localparam logic signed [V_W-1:0] JUMP_NEG  = V_W'(-JUMP_V);
   localparam logic signed [V_W-1:0] BOOST_NEG = V_W'(-BOOST_V);
   localparam logic signed [V_W:0]   GRAV_EXT  = (V_W+1)'(GRAVITY);
   localparam logic signed [V_W:0]   VMAX_EXT  = (V_W+1)'(VMAX_FALL);

   logic dtick;
   logic gtick;

   state_e                  state_q;
   logic [Y_W-1:0]          y_q;
   logic signed [V_W-1:0]   vel_q;
   logic                    jump_q;
   logic                    falling_q;
   logic                    dead_q;

   logic signed [Y_W:0]     y_sum;
   logic [Y_W-1:0]          y_step;
   logic signed [V_W:0]     vel_ext;
   logic signed [V_W:0]     vel_inc;
   logic signed [V_W-1:0]   vel_grav;

   tick_sync u_doodle_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (doodle_clk),
      .tick     (dtick)
   );

   tick_sync u_gravity_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (gravity_clk),
      .tick     (gtick)
   );

   // Candidate position and velocity for this cycle, both from the old velocity.
   always_comb begin
      y_sum    = $signed({1'b0, y_q}) + $signed({{(Y_W+1-V_W){vel_q[V_W-1]}}, vel_q});
      vel_ext  = $signed({vel_q[V_W-1], vel_q});
      vel_inc  = vel_ext + GRAV_EXT;
      y_step   = y_q;
      vel_grav = vel_q;
      if (dtick) begin
         if (y_sum[Y_W]) begin
            y_step = '0;
         end else begin
            y_step = y_sum[Y_W-1:0];
         end
      end else begin
         y_step = y_q;
      end
      if (gtick) begin
         if (vel_inc > VMAX_EXT) begin
            vel_grav = VMAX_EXT[V_W-1:0];
         end else begin
            vel_grav = vel_inc[V_W-1:0];
         end
      end else begin
         vel_grav = vel_q;
      end
   end

   // Motion FSM; death outranks a bounce, and a bounce discards a same-cycle gravity tick.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         y_q       <= Y_START_C;
         vel_q     <= '0;
         jump_q    <= 1'b0;
         falling_q <= 1'b0;
         dead_q    <= 1'b0;
      end else begin
         jump_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_DEAD: begin
               if (start) begin
                  state_q   <= ST_ASCEND;
                  y_q       <= Y_START_C;
                  vel_q     <= JUMP_NEG;
                  jump_q    <= 1'b1;
                  falling_q <= 1'b0;
                  dead_q    <= 1'b0;
               end
            end
            ST_ASCEND, ST_DESCEND: begin
               if (y_step >= FLOOR_C) begin
                  state_q   <= ST_DEAD;
                  y_q       <= y_step;
                  vel_q     <= '0;
                  falling_q <= 1'b0;
                  dead_q    <= 1'b1;
               end else if ((state_q == ST_DESCEND) && dtick && landed) begin
                  state_q   <= ST_ASCEND;
                  vel_q     <= power_signal ? BOOST_NEG : JUMP_NEG;
                  jump_q    <= 1'b1;
                  falling_q <= 1'b0;
               end else begin
                  y_q   <= y_step;
                  vel_q <= vel_grav;
                  if (!vel_grav[V_W-1]) begin
                     state_q   <= ST_DESCEND;
                     falling_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               y_q       <= Y_START_C;
               vel_q     <= '0;
               falling_q <= 1'b0;
               dead_q    <= 1'b0;
            end
         endcase
      end
   end

   assign doodle_y   = y_q;
   assign velocity   = vel_q;
   assign jump_pulse = jump_q;
   assign falling    = falling_q;
   assign dead       = dead_q;

endmodule

// File: tb/tb_doodle_vmotion.sv
// Bench for doodle_vmotion: directed scenarios plus random play against a behavioural model.
module tb_doodle_vmotion;

   localparam int M_IDLE = 0;
   localparam int M_ASC  = 1;
   localparam int M_DESC = 2;
   localparam int M_DEAD = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic doodle_clk = 1'b0;
   logic gravity_clk = 1'b0;
   logic start = 1'b0;
   logic landed = 1'b0;
   logic power_signal = 1'b0;
   logic [9:0] doodle_y;
   logic signed [7:0] velocity;
   logic jump_pulse;
   logic falling;
   logic dead;

   int checks = 0;
   int failures = 0;

   int m_st;
   int m_y;
   int m_v;
   bit m_jp;
   bit [2:0] dh;
   bit [2:0] gh;

   doodle_vmotion dut (
      .clk          (clk),
      .rst          (rst),
      .doodle_clk   (doodle_clk),
      .gravity_clk  (gravity_clk),
      .start        (start),
      .landed       (landed),
      .power_signal (power_signal),
      .doodle_y     (doodle_y),
      .velocity     (velocity),
      .jump_pulse   (jump_pulse),
      .falling      (falling),
      .dead         (dead)
   );

   always #5 clk = ~clk;

   // Reference behaviour: a slow input seen high two edges ago but low three edges ago is a tick now.
   task automatic model_edge();
      bit td;
      bit tg;
      int ny;
      int nv;
      if (!rst) begin
         m_st = M_IDLE; m_y = 400; m_v = 0; m_jp = 0; dh = 3'b000; gh = 3'b000;
      end else begin
         td = dh[1] && !dh[2];
         tg = gh[1] && !gh[2];
         dh = {dh[1:0], doodle_clk};
         gh = {gh[1:0], gravity_clk};
         m_jp = 0;
         if (m_st == M_IDLE || m_st == M_DEAD) begin
            if (start) begin
               m_st = M_ASC; m_y = 400; m_v = -8; m_jp = 1;
            end
         end else begin
            ny = td ? m_y + m_v : m_y;
            if (ny < 0) ny = 0;
            nv = tg ? ((m_v + 1 > 8) ? 8 : m_v + 1) : m_v;
            if (ny >= 460) begin
               m_st = M_DEAD; m_y = ny; m_v = 0;
            end else if (m_st == M_DESC && td && landed) begin
               m_st = M_ASC; m_v = power_signal ? -16 : -8; m_jp = 1;
            end else begin
               m_y = ny; m_v = nv;
               if (nv >= 0) m_st = M_DESC;
            end
         end
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         model_edge();
      end
      #1;
   endtask

   task automatic dtick();
      doodle_clk = 1'b1; step(4);
      doodle_clk = 1'b0; step(2);
   endtask

   task automatic gtick();
      gravity_clk = 1'b1; step(4);
      gravity_clk = 1'b0; step(2);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      step(2);
      checks++; if (doodle_y !== 10'd400) begin failures++; $display("FAIL reset_y got=%0d exp=400", doodle_y); end
      checks++; if (velocity !== 8'sd0) begin failures++; $display("FAIL reset_v got=%0d exp=0", velocity); end
      checks++; if ({jump_pulse, falling, dead} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {jump_pulse, falling, dead}); end
      rst = 1'b1;
      dtick();
      checks++; if (doodle_y !== 10'd400 || velocity !== 8'sd0) begin failures++; $display("FAIL idle_ignores_tick got=%0d/%0d exp=400/0", doodle_y, velocity); end
   endtask

   task automatic test_start();
      start = 1'b1; step(1); start = 1'b0;
      checks++; if (jump_pulse !== 1'b1) begin failures++; $display("FAIL start_jp got=%b exp=1", jump_pulse); end
      checks++; if (velocity !== -8'sd8) begin failures++; $display("FAIL start_v got=%0d exp=-8", velocity); end
      checks++; if (doodle_y !== 10'd400 || falling !== 1'b0 || dead !== 1'b0) begin failures++; $display("FAIL start_state got=%0d f=%b d=%b exp=400 0 0", doodle_y, falling, dead); end
      step(1);
      checks++; if (jump_pulse !== 1'b0) begin failures++; $display("FAIL start_jp_width got=%b exp=0", jump_pulse); end
   endtask

   task automatic test_single_tick();
      doodle_clk = 1'b1; step(2);
      checks++; if (doodle_y !== 10'd400) begin failures++; $display("FAIL tick_early got=%0d exp=400", doodle_y); end
      step(1);
      checks++; if (doodle_y !== 10'd392) begin failures++; $display("FAIL tick_latency got=%0d exp=392", doodle_y); end
      step(200);
      checks++; if (doodle_y !== 10'd392) begin failures++; $display("FAIL tick_held_high got=%0d exp=392", doodle_y); end
      doodle_clk = 1'b0; step(5);
      checks++; if (doodle_y !== 10'd392) begin failures++; $display("FAIL tick_falling_edge got=%0d exp=392", doodle_y); end
   endtask

   task automatic test_gravity();
      for (int i = 0; i < 7; i++) gtick();
      checks++; if (velocity !== -8'sd1 || falling !== 1'b0) begin failures++; $display("FAIL grav_7 got=%0d f=%b exp=-1 0", velocity, falling); end
      gtick();
      checks++; if (velocity !== 8'sd0 || falling !== 1'b1) begin failures++; $display("FAIL grav_8 got=%0d f=%b exp=0 1", velocity, falling); end
      for (int i = 0; i < 10; i++) gtick();
      checks++; if (velocity !== 8'sd8) begin failures++; $display("FAIL grav_saturate got=%0d exp=8", velocity); end
   endtask

   task automatic test_bounce();
      landed = 1'b1; power_signal = 1'b0; doodle_clk = 1'b1; step(3);
      checks++; if (jump_pulse !== 1'b1 || velocity !== -8'sd8) begin failures++; $display("FAIL bounce_normal got=jp%b v%0d exp=jp1 v-8", jump_pulse, velocity); end
      checks++; if (doodle_y !== 10'd392 || falling !== 1'b0) begin failures++; $display("FAIL bounce_hold_y got=%0d f=%b exp=392 0", doodle_y, falling); end
      step(1);
      checks++; if (jump_pulse !== 1'b0) begin failures++; $display("FAIL bounce_jp_width got=%b exp=0", jump_pulse); end
      landed = 1'b0; doodle_clk = 1'b0; step(2);
      for (int i = 0; i < 8; i++) gtick();
      landed = 1'b1; power_signal = 1'b1; doodle_clk = 1'b1; step(3);
      checks++; if (jump_pulse !== 1'b1 || velocity !== -8'sd16) begin failures++; $display("FAIL bounce_boost got=jp%b v%0d exp=jp1 v-16", jump_pulse, velocity); end
      step(1);
      landed = 1'b0; power_signal = 1'b0; doodle_clk = 1'b0; step(2);
   endtask

   task automatic test_death();
      for (int i = 0; i < 23; i++) gtick();
      dtick();
      gtick();
      for (int i = 0; i < 7; i++) dtick();
      checks++; if (doodle_y !== 10'd455 || velocity !== 8'sd8) begin failures++; $display("FAIL death_setup got=%0d/%0d exp=455/8", doodle_y, velocity); end
      landed = 1'b1; doodle_clk = 1'b1; step(3);
      checks++; if (dead !== 1'b1 || velocity !== 8'sd0 || jump_pulse !== 1'b0) begin failures++; $display("FAIL death_over_bounce got=d%b v%0d jp%b exp=d1 v0 jp0", dead, velocity, jump_pulse); end
      checks++; if (doodle_y !== 10'd463) begin failures++; $display("FAIL death_y got=%0d exp=463", doodle_y); end
      landed = 1'b0; doodle_clk = 1'b0; step(2);
      dtick(); gtick();
      checks++; if (doodle_y !== 10'd463 || velocity !== 8'sd0 || dead !== 1'b1) begin failures++; $display("FAIL dead_hold got=%0d/%0d d%b exp=463/0 d1", doodle_y, velocity, dead); end
      start = 1'b1; step(1); start = 1'b0;
      checks++; if (doodle_y !== 10'd400 || velocity !== -8'sd8 || jump_pulse !== 1'b1 || dead !== 1'b0) begin failures++; $display("FAIL dead_restart got=%0d/%0d jp%b d%b exp=400/-8 jp1 d0", doodle_y, velocity, jump_pulse, dead); end
   endtask

   task automatic test_coincident();
      for (int i = 0; i < 36; i++) dtick();
      for (int i = 0; i < 4; i++) gtick();
      for (int i = 0; i < 3; i++) dtick();
      gtick();
      checks++; if (doodle_y !== 10'd100 || velocity !== -8'sd3) begin failures++; $display("FAIL coinc_setup got=%0d/%0d exp=100/-3", doodle_y, velocity); end
      doodle_clk = 1'b1; gravity_clk = 1'b1; step(4);
      checks++; if (doodle_y !== 10'd97 || velocity !== -8'sd2) begin failures++; $display("FAIL coinc_old_vel got=%0d/%0d exp=97/-2", doodle_y, velocity); end
      doodle_clk = 1'b0; gravity_clk = 1'b0; step(2);
   endtask

   task automatic test_clamp();
      gtick(); gtick(); gtick();
      dtick();
      landed = 1'b1; dtick(); landed = 1'b0;
      checks++; if (doodle_y !== 10'd98 || velocity !== -8'sd8) begin failures++; $display("FAIL clamp_setup got=%0d/%0d exp=98/-8", doodle_y, velocity); end
      for (int i = 0; i < 12; i++) dtick();
      checks++; if (doodle_y !== 10'd2) begin failures++; $display("FAIL clamp_pre got=%0d exp=2", doodle_y); end
      dtick();
      checks++; if (doodle_y !== 10'd0) begin failures++; $display("FAIL clamp_zero got=%0d exp=0", doodle_y); end
   endtask

   task automatic test_reset_mid_run();
      step(1);
      #2 rst = 1'b0;
      #1;
      checks++; if (doodle_y !== 10'd400 || velocity !== 8'sd0 || {jump_pulse, falling, dead} !== 3'b000) begin failures++; $display("FAIL async_reset got=%0d/%0d %b exp=400/0 000", doodle_y, velocity, {jump_pulse, falling, dead}); end
      step(2);
      rst = 1'b1;
      step(1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) doodle_clk = ~doodle_clk;
         if ($urandom_range(0, 5) == 0) gravity_clk = ~gravity_clk;
         landed       = ($urandom_range(0, 1) == 1);
         power_signal = ($urandom_range(0, 1) == 1);
         start        = ($urandom_range(0, 47) == 0);
         step(1);
         checks++;
         if (doodle_y !== 10'(m_y) || velocity !== 8'(m_v) || jump_pulse !== m_jp ||
             falling !== (m_st == M_DESC) || dead !== (m_st == M_DEAD)) begin
            failures++;
            $display("FAIL random_cycle%0d got=y%0d v%0d jp%b f%b d%b exp=y%0d v%0d jp%b st%0d",
                     i, doodle_y, velocity, jump_pulse, falling, dead, m_y, m_v, m_jp, m_st);
         end
      end
      start = 1'b0; landed = 1'b0; power_signal = 1'b0;
   endtask

   initial begin
      test_reset();
      test_start();
      test_single_tick();
      test_gravity();
      test_bounce();
      test_death();
      test_coincident();
      test_clamp();
      test_reset_mid_run();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/doodle_vmotion.md
Name: doodle_vmotion

Overview:
- Vertical-motion controller for the doodle sprite, directly downstream of the game clock divider.
- Samples the divider's slow square-wave outputs (doodle_clk, gravity_clk) as data in the 50 MHz domain and converts their rising edges into one-cycle ticks.
- On each tick it integrates velocity and position: bounces on platforms, applies a spring boost, and declares death on falling off-screen.
- Outputs feed the VGA sprite renderer and the score/collision logic.

Parameters:
- Y_W, 10, position width (pixels, y grows downward)
- V_W, 8, signed velocity width (pixels per doodle tick)
- Y_START, 400, y loaded on reset and on start
- FLOOR_Y, 460, y at or beyond which the doodle is dead (SCREEN_H 480 minus DOODLE_H 20)
- JUMP_V, 8, upward speed magnitude for a normal bounce
- BOOST_V, 16, upward speed magnitude when power_signal is high at bounce
- GRAVITY, 1, velocity increment per gravity tick
- VMAX_FALL, 8, maximum positive (downward) velocity

Ports:
- clk  in  1  master clock, 50 MHz
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- doodle_clk  in  1  divider square wave, 200 Hz; rising edge = position step
- gravity_clk  in  1  divider square wave, 100 Hz; rising edge = velocity step
- start  in  1  level; leaves IDLE or DEAD and starts a new run
- landed  in  1  level from collision logic: doodle feet overlap a platform
- power_signal  in  1  level; selects BOOST_V at bounce
- doodle_y  out  Y_W  current top-of-sprite y
- velocity  out  V_W  signed current velocity
- jump_pulse  out  1  one-cycle pulse on each bounce
- falling  out  1  high in DESCEND
- dead  out  1  high in DEAD

Behaviour:
- Reset (rst=0, async) gives:
  - state=IDLE, doodle_y=Y_START, velocity=0, jump_pulse=0, falling=0, dead=0.
  - Synchronizer flops cleared to 0.
- Tick generation:
  - Each slow input goes through a 2-flop synchronizer plus a previous-value flop.
  - tick = sync & ~prev.
  - Latency is 3 clk from the input rising edge to the tick.
  - Falling edges produce nothing. Exactly one tick per rising edge.
- States: IDLE, ASCEND, DESCEND, DEAD.
- IDLE:
  - Ignores ticks.
  - start=1 → ASCEND with velocity=-JUMP_V and jump_pulse=1.
- ASCEND / DESCEND, on gravity tick:
  - velocity <= min(velocity+GRAVITY, VMAX_FALL). Signed arithmetic; no wrap.
- ASCEND / DESCEND, on doodle tick:
  - next_y = doodle_y + sign-extended velocity, computed at Y_W+1 bits signed.
  - next_y < 0 clamps to 0.
  - Uses the velocity registered before this cycle's update.
- Simultaneous gravity and doodle tick in one cycle: both updates occur in parallel; the position uses the old velocity.
- ASCEND → DESCEND when the updated velocity is >= 0.
- DESCEND, on doodle tick with landed=1:
  - velocity <= -(power_signal ? BOOST_V : JUMP_V); doodle_y holds.
  - jump_pulse=1 for that cycle; → ASCEND.
  - A gravity tick in the same cycle is discarded.
- landed is ignored in ASCEND (platforms are passable going up).
- Any state except IDLE: doodle_y >= FLOOR_Y after an update → DEAD next cycle.
  - velocity <= 0, dead=1.
  - Death takes priority over a bounce in the same cycle.
- DEAD:
  - Holds all values.
  - start=1 → doodle_y=Y_START, velocity=-JUMP_V, jump_pulse=1, → ASCEND.
- start in ASCEND/DESCEND has no effect.
- Output timing: outputs are registered. falling = (state==DESCEND); dead = (state==DEAD).
- Reset mid-run: immediate return to IDLE values; no tick is generated by the first sampled high after reset release unless a 0→1 transition is seen.

Decomposition:
- Package doodle_pkg:
  - state enum (IDLE, ASCEND, DESCEND, DEAD)
  - SCREEN_H=480, DOODLE_H=20, Y_W, V_W
  - default JUMP_V, BOOST_V, GRAVITY, VMAX_FALL
- Sub-module tick_sync: 2-flop synchronizer plus rising-edge detector (ports clk, rst, async_in, tick). Instantiated twice.

Test Plan:
- Reset, start=1 for one cycle → jump_pulse high exactly one cycle; velocity=-8; state ASCEND; doodle_y=400.
- Single doodle_clk rising edge → tick 3 clk later; doodle_y 400→392; exactly one step even with doodle_clk held high for 250000 cycles.
- Eight gravity ticks from velocity -8 → velocity reaches 0, falling=1; further ticks saturate at +8, never 9.
- DESCEND with landed=1 on a doodle tick:
  - power_signal=0 → velocity=-8, jump_pulse=1.
  - Repeat with power_signal=1 → velocity=-16.
- doodle_y=455, velocity=+8, doodle tick with landed=1 → DEAD (dead=1, velocity=0, no jump_pulse); start=1 → doodle_y=400, ASCEND.
- Gravity and doodle ticks coincident at doodle_y=100, velocity=-3 → doodle_y=97, velocity=-2.
- Separately: doodle_y=2, velocity=-8 → doodle_y clamps to 0.
- Assert rst=0 mid-ASCEND asynchronously → outputs at reset values within the same cycle.
